// File: rtl/axi4_rd_sched_arbiter_if.sv
// Bus bundle for axi4_rd_sched_arbiter: NUM requester AR/R channels plus the shared AXI4 read master port.
// master = the scheduler's view; slave = requesters and downstream packet FIFO.
interface axi4_rd_sched_arbiter_if #(
  parameter int NUM    = 4,
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 8,
  parameter int IDSIZE = 4,
  parameter int DSIZE  = 32
);
  logic [NUM-1:0]        s_arvalid;
  logic [NUM-1:0]        s_arready;
  logic [NUM*ASIZE-1:0]  s_araddr;
  logic [NUM*LSIZE-1:0]  s_arlen;
  logic [NUM*IDSIZE-1:0] s_arid;
  logic [NUM-1:0]        s_rvalid;
  logic [NUM-1:0]        s_rready;
  logic [DSIZE-1:0]      s_rdata;
  logic [IDSIZE-1:0]     s_rid;
  logic                  s_rlast;

  logic                  m_arvalid;
  logic                  m_arready;
  logic [ASIZE-1:0]      m_araddr;
  logic [LSIZE-1:0]      m_arlen;
  logic [IDSIZE-1:0]     m_arid;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [DSIZE-1:0]      m_rdata;
  logic [IDSIZE-1:0]     m_rid;
  logic                  m_rlast;

  modport master (
    input  s_arvalid, s_araddr, s_arlen, s_arid, s_rready,
           m_arready, m_rvalid, m_rdata, m_rid, m_rlast,
    output s_arready, s_rvalid, s_rdata, s_rid, s_rlast,
           m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );

  modport slave (
    output s_arvalid, s_araddr, s_arlen, s_arid, s_rready,
           m_arready, m_rvalid, m_rdata, m_rid, m_rlast,
    input  s_arready, s_rvalid, s_rdata, s_rid, s_rlast,
           m_arvalid, m_araddr, m_arlen, m_arid, m_rready
  );
endinterface

// File: rtl/axi4_rd_sched_arbiter.sv
// Round-robin AR scheduler sharing one AXI4 read master among NUM requesters; R bursts steered back in issue order.
// Latency: s_arready pulse in T, m_arvalid from T+1 (one AR per 2 cycles); R path combinational, zero added latency.
// Backpressure: no grant while hold is full or DEPTH bursts are outstanding; m_rready follows the head requester. AXI4_RD_SCHED_WDOG_EN adds a sticky R-stall watchdog.
module axi4_rd_sched_arbiter #(
  parameter int NUM    = 4,
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 8,
  parameter int IDSIZE = 4,
  parameter int DSIZE  = 32,
  parameter int DEPTH  = 4,
  parameter int WDOG   = 1024
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  axi4_rd_sched_arbiter_if.master bus,
  output logic [4:0]             outstanding,
  output logic                   wdog_err
);
  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic              hold_vld_q, hold_vld_d;
  logic [ASIZE-1:0]  hold_addr_q, hold_addr_d;
  logic [LSIZE-1:0]  hold_len_q, hold_len_d;
  logic [IDSIZE-1:0] hold_id_q, hold_id_d;
  logic [IW-1:0]     hold_idx_q, hold_idx_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [IW-1:0]     ord_mem_q [DEPTH];
  logic [IW-1:0]     ord_mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     ord_cnt_q, ord_cnt_d;

  logic              ord_empty;
  logic [IW-1:0]     head_idx;
  logic [4:0]        outstanding_w;
  logic              grant_ok;
  logic              grant_vld;
  logic [IW-1:0]     grant_idx;
  logic [IW:0]       cand_sum;
  logic [IW-1:0]     cand;
  logic              ar_hs;
  logic              r_hs;
  logic              push;
  logic              pop;
  logic              m_rready_w;
  logic [NUM-1:0]    s_arready_w;
  logic [NUM-1:0]    s_rvalid_w;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ord_empty     = (ord_cnt_q == '0);
  assign head_idx      = ord_mem_q[rd_ptr_q];
  assign outstanding_w = 5'(hold_vld_q) + 5'(ord_cnt_q);
  assign outstanding   = outstanding_w;

  // Reset gates the grant so s_arready stays low while axi_aresetn is asserted.
  assign grant_ok = axi_aresetn && !hold_vld_q && (outstanding_w < 5'(DEPTH));

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NUM; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (cand_sum >= (IW+1)'(NUM)) cand_sum = cand_sum - (IW+1)'(NUM);
      cand = cand_sum[IW-1:0];
      if (!grant_vld && bus.s_arvalid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant_vld = grant_vld && grant_ok;
  end

  always_comb begin
    s_arready_w = '0;
    if (grant_vld) s_arready_w[grant_idx] = 1'b1;
  end

  assign bus.s_arready = s_arready_w;
  assign bus.m_arvalid = hold_vld_q;
  assign bus.m_araddr  = hold_addr_q;
  assign bus.m_arlen   = hold_len_q;
  assign bus.m_arid    = hold_id_q;

  assign ar_hs = hold_vld_q && bus.m_arready;

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_addr_d = hold_addr_q;
    hold_len_d  = hold_len_q;
    hold_id_d   = hold_id_q;
    hold_idx_d  = hold_idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (ar_hs) hold_vld_d = 1'b0;
    if (grant_vld) begin
      hold_vld_d  = 1'b1;
      hold_addr_d = bus.s_araddr[grant_idx*ASIZE +: ASIZE];
      hold_len_d  = bus.s_arlen[grant_idx*LSIZE +: LSIZE];
      hold_id_d   = bus.s_arid[grant_idx*IDSIZE +: IDSIZE];
      hold_idx_d  = grant_idx;
      rr_ptr_d    = (grant_idx == IW'(NUM - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  // R steering: bursts return in issue order, so the queue head owns the channel.
  always_comb begin
    s_rvalid_w = '0;
    m_rready_w = 1'b0;
    if (!ord_empty) begin
      s_rvalid_w[head_idx] = bus.m_rvalid;
      m_rready_w           = bus.s_rready[head_idx];
    end
  end

  assign bus.s_rvalid = s_rvalid_w;
  assign bus.m_rready = m_rready_w;
  assign bus.s_rdata  = bus.m_rdata;
  assign bus.s_rid    = bus.m_rid;
  assign bus.s_rlast  = bus.m_rlast;

  assign r_hs = bus.m_rvalid && m_rready_w;
  assign push = ar_hs;
  assign pop  = r_hs && bus.m_rlast;

  always_comb begin
    ord_mem_d = ord_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ord_cnt_d = ord_cnt_q;
    if (push) begin
      ord_mem_d[wr_ptr_q] = hold_idx_q;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   ord_cnt_d = ord_cnt_q + CW'(1);
      2'b01:   ord_cnt_d = ord_cnt_q - CW'(1);
      default: ord_cnt_d = ord_cnt_q;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      hold_vld_q  <= 1'b0;
      hold_addr_q <= '0;
      hold_len_q  <= '0;
      hold_id_q   <= '0;
      hold_idx_q  <= '0;
      rr_ptr_q    <= '0;
      ord_mem_q   <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ord_cnt_q   <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_addr_q <= hold_addr_d;
      hold_len_q  <= hold_len_d;
      hold_id_q   <= hold_id_d;
      hold_idx_q  <= hold_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      ord_mem_q   <= ord_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ord_cnt_q   <= ord_cnt_d;
    end
  end

`ifdef AXI4_RD_SCHED_WDOG_EN
  localparam int WW = $clog2(WDOG + 1);

  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_err_q, wdog_err_d;

  always_comb begin
    wdog_cnt_d = '0;
    if (!ord_empty && !r_hs)
      wdog_cnt_d = (wdog_cnt_q == WW'(WDOG)) ? wdog_cnt_q : wdog_cnt_q + WW'(1);
    wdog_err_d = wdog_err_q || (wdog_cnt_d == WW'(WDOG));
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi4_rd_sched_arbiter.sv
// Directed + randomized bench for axi4_rd_sched_arbiter against a queue-based reference model.
module tb_axi4_rd_sched_arbiter;
  localparam int NUM = 4, ASIZE = 32, LSIZE = 8, IDSIZE = 4, DSIZE = 32, DEPTH = 4, WDOG = 16;
`ifdef AXI4_RD_SCHED_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_rd_sched_arbiter_if #(.NUM(NUM), .ASIZE(ASIZE), .LSIZE(LSIZE), .IDSIZE(IDSIZE), .DSIZE(DSIZE)) bus ();
  logic [4:0] outstanding;
  logic       wdog_err;

  axi4_rd_sched_arbiter #(
    .NUM(NUM), .ASIZE(ASIZE), .LSIZE(LSIZE), .IDSIZE(IDSIZE), .DSIZE(DSIZE), .DEPTH(DEPTH), .WDOG(WDOG)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .bus(bus), .outstanding(outstanding), .wdog_err(wdog_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one-entry hold, FIFO of granted requesters, round-robin pointer.
  bit               m_hold_v;
  int               m_hold_idx;
  logic [ASIZE-1:0] m_hold_addr;
  logic [LSIZE-1:0] m_hold_len;
  logic [IDSIZE-1:0] m_hold_id;
  int               m_rr;
  int               m_order[$];
  int               m_stall;
  bit               m_wdog;
  int               grant_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold_v = 0; m_hold_idx = 0; m_hold_addr = '0; m_hold_len = '0; m_hold_id = '0;
    m_rr = 0; m_order.delete(); m_stall = 0; m_wdog = 0;
  endtask

  task automatic drive_idle();
    bus.s_arvalid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arid = '0; bus.s_rready = '0;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_rid = '0; bus.m_rlast = 1'b0;
  endtask

  function automatic int model_grant();
    int c;
    if (!rst_n || m_hold_v || (int'(m_hold_v) + m_order.size()) >= DEPTH) return -1;
    for (int i = 0; i < NUM; i++) begin
      c = (m_rr + i) % NUM;
      if (bus.s_arvalid[c]) return c;
    end
    return -1;
  endfunction

  // Called at a falling edge with inputs already driven; checks outputs, advances model over the rising edge.
  task automatic step();
    int g, h;
    logic [NUM-1:0] exp_arready, exp_rvalid;
    logic exp_mrready;
    bit pop, push;
    #2;
    g = model_grant();
    exp_arready = '0;
    if (g >= 0) exp_arready[g] = 1'b1;
    check("s_arready", 64'(bus.s_arready), 64'(exp_arready));
    check("m_arvalid", 64'(bus.m_arvalid), 64'(m_hold_v));
    if (m_hold_v) begin
      check("m_araddr", 64'(bus.m_araddr), 64'(m_hold_addr));
      check("m_arlen", 64'(bus.m_arlen), 64'(m_hold_len));
      check("m_arid", 64'(bus.m_arid), 64'(m_hold_id));
    end
    check("outstanding", 64'(outstanding), 64'(int'(m_hold_v) + m_order.size()));
    exp_rvalid = '0;
    exp_mrready = 1'b0;
    if (m_order.size() > 0) begin
      h = m_order[0];
      exp_rvalid[h] = bus.m_rvalid;
      exp_mrready = bus.s_rready[h];
    end
    check("s_rvalid", 64'(bus.s_rvalid), 64'(exp_rvalid));
    check("m_rready", 64'(bus.m_rready), 64'(exp_mrready));
    check("s_rdata", 64'(bus.s_rdata), 64'(bus.m_rdata));
    check("s_rlast", 64'(bus.s_rlast), 64'(bus.m_rlast));
    check("wdog_err", 64'(wdog_err), 64'(WD_ON && m_wdog));
    pop  = bus.m_rvalid && exp_mrready && bus.m_rlast;
    push = m_hold_v && bus.m_arready;
    if (m_order.size() > 0 && !(bus.m_rvalid && exp_mrready)) m_stall++;
    else m_stall = 0;
    if (m_stall >= WDOG) m_wdog = 1;
    if (pop) void'(m_order.pop_front());
    if (push) begin
      m_order.push_back(m_hold_idx);
      m_hold_v = 0;
    end
    if (g >= 0) begin
      m_hold_v    = 1;
      m_hold_idx  = g;
      m_hold_addr = bus.s_araddr[g*ASIZE +: ASIZE];
      m_hold_len  = bus.s_arlen[g*LSIZE +: LSIZE];
      m_hold_id   = bus.s_arid[g*IDSIZE +: IDSIZE];
      m_rr        = (g + 1) % NUM;
      grant_log.push_back(g);
    end
    @(negedge clk);
  endtask

  task automatic drive_rand();
    for (int i = 0; i < NUM; i++) begin
      bus.s_arvalid[i] = ($urandom_range(99) < 50);
      bus.s_araddr[i*ASIZE +: ASIZE] = ASIZE'($urandom);
      bus.s_arlen[i*LSIZE +: LSIZE] = LSIZE'($urandom);
      bus.s_arid[i*IDSIZE +: IDSIZE] = IDSIZE'($urandom);
      bus.s_rready[i] = ($urandom_range(99) < 70);
    end
    bus.m_arready = ($urandom_range(99) < 70);
    bus.m_rvalid  = ($urandom_range(99) < 60);
    bus.m_rlast   = ($urandom_range(3) == 0);
    bus.m_rdata   = DSIZE'($urandom);
    bus.m_rid     = IDSIZE'($urandom);
  endtask

  task automatic drain();
    bus.s_arvalid = '0; bus.m_arready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.s_rready = '1;
    for (int k = 0; k < 40 && (m_order.size() > 0 || m_hold_v); k++) step();
    #1;
    check("drain_outstanding", 64'(outstanding), 64'd0);
  endtask

  initial begin
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};
    drive_idle();
    model_reset();
    // Reset state, with requests and R traffic presented to prove the outputs are held low.
    bus.s_arvalid = '1; bus.m_rvalid = 1'b1; bus.s_rready = '1;
    #2;
    check("rst_s_arready", 64'(bus.s_arready), 64'd0);
    check("rst_m_arvalid", 64'(bus.m_arvalid), 64'd0);
    check("rst_m_araddr", 64'(bus.m_araddr), 64'd0);
    check("rst_m_arlen", 64'(bus.m_arlen), 64'd0);
    check("rst_m_arid", 64'(bus.m_arid), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_s_rvalid", 64'(bus.s_rvalid), 64'd0);
    check("rst_m_rready", 64'(bus.m_rready), 64'd0);
    check("rst_wdog", 64'(wdog_err), 64'd0);
    @(negedge clk); @(negedge clk);
    drive_idle();
    rst_n = 1'b1;

    // Round robin, all requesters asserted, zero-length bursts drained immediately.
    grant_log.delete();
    bus.s_arvalid = '1; bus.m_arready = 1'b1; bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.s_rready = '1;
    for (int k = 0; k < 10; k++) step();
    check("rr_count", 64'(grant_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) check("rr_order", 64'(grant_log[k]), 64'(exp_rr[k]));
    drain();

    // Single request from requester 2, 4-beat burst.
    drive_idle();
    bus.s_arvalid = 4'b0100; bus.m_arready = 1'b1;
    bus.s_araddr[2*ASIZE +: ASIZE] = 32'h100; bus.s_arlen[2*LSIZE +: LSIZE] = 8'd3; bus.s_arid[2*IDSIZE +: IDSIZE] = 4'd5;
    #1; check("single_arready", 64'(bus.s_arready), 64'h4); check("single_out0", 64'(outstanding), 64'd0);
    step();
    bus.s_arvalid = '0;
    #1; check("single_m_arvalid", 64'(bus.m_arvalid), 64'd1); check("single_m_araddr", 64'(bus.m_araddr), 64'h100);
    check("single_out1", 64'(outstanding), 64'd1);
    step();
    for (int b = 0; b < 4; b++) begin
      bus.m_rvalid = 1'b1; bus.m_rlast = (b == 3); bus.s_rready = '1; bus.m_rdata = DSIZE'(32'hA0 + b);
      #1; check("single_s_rvalid", 64'(bus.s_rvalid), 64'h4); check("single_out_beat", 64'(outstanding), 64'd1);
      step();
    end
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
    #1; check("single_out_end", 64'(outstanding), 64'd0);
    step();

    // DEPTH cap: R withheld while every requester keeps asking.
    grant_log.delete();
    bus.s_arvalid = '1; bus.m_arready = 1'b1; bus.m_rvalid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    #1;
    check("cap_grants", 64'(grant_log.size()), 64'd4);
    check("cap_outstanding", 64'(outstanding), 64'd4);
    check("cap_arready", 64'(bus.s_arready), 64'd0);
    check("cap_wdog", 64'(wdog_err), 64'(WD_ON));
    bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.s_rready = '1;
    step();
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
    #1; check("cap_out_after_pop", 64'(outstanding), 64'd3); check("cap_regrant", 64'(|bus.s_arready), 64'd1);
    step();
    check("cap_fifth_grant", 64'(grant_log.size()), 64'd5);
    drain();
    check("wdog_sticky", 64'(wdog_err), 64'(WD_ON));

    // Grant and rlast pop in the same cycle leave the count unchanged.
    drive_idle();
    bus.s_arvalid = '1; bus.m_arready = 1'b1;
    for (int k = 0; k < 20 && !(m_order.size() == 3 && !m_hold_v); k++) step();
    bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.s_rready = '1;
    #1; check("simul_pre_out", 64'(outstanding), 64'd3); check("simul_grant", 64'(|bus.s_arready), 64'd1);
    check("simul_mrready", 64'(bus.m_rready), 64'd1);
    step();
    bus.s_arvalid = '0; bus.m_rlast = 1'b0;
    #1; check("simul_post_out", 64'(outstanding), 64'd3);
    // Backpressure: m_rready mirrors the head requester's s_rready.
    for (int k = 0; k < 6; k++) begin
      bus.s_rready = (k % 2) ? '1 : '0;
      #1; check("bp_mrready", 64'(bus.m_rready), 64'(k % 2));
      step();
    end
    drain();

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      drive_rand();
      step();
    end
    drain();

    // Reset mid-burst, then confirm arbitration restarts at requester 0.
    drive_idle();
    bus.s_arvalid = 4'b0010; bus.m_arready = 1'b1;
    step();
    bus.s_arvalid = '0;
    step();
    bus.m_rvalid = 1'b1; bus.m_rlast = 1'b0; bus.s_rready = '1;
    step();
    #2; rst_n = 1'b0; #1;
    check("mid_rst_s_rvalid", 64'(bus.s_rvalid), 64'd0);
    check("mid_rst_m_rready", 64'(bus.m_rready), 64'd0);
    check("mid_rst_m_arvalid", 64'(bus.m_arvalid), 64'd0);
    check("mid_rst_outstanding", 64'(outstanding), 64'd0);
    check("mid_rst_wdog", 64'(wdog_err), 64'd0);
    model_reset();
    drive_idle();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    bus.s_arvalid = 4'b1010; bus.m_arready = 1'b1;
    #1; check("post_rst_rr0", 64'(bus.s_arready), 64'h2);
    step();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
